// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: the integer and RNS register-file write requests each have their own
// queue. The two queues are merged round-robin onto one registered write port.
// A pending bitmap marks every register that still has a write in flight.
module reg_wb_arbiter #(
  parameter int NUM_DOMAINS = 2,
  parameter int FIFO_DEPTH  = 4   // power of two, at least 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     int_valid,
  output logic                     int_ready,
  input  logic [2:0]               int_addr,
  input  logic [7:0]               int_data,
  input  logic                     rns_valid,
  output logic                     rns_ready,
  input  logic [2:0]               rns_addr,
  input  logic [NUM_DOMAINS*8-1:0] rns_data,
  output logic                     wr_en,
  output logic [3:0]               wr_addr,
  output logic [NUM_DOMAINS*8-1:0] wr_data,
  output logic [15:0]              pending,
  output logic                     idle
);

  localparam int          W       = NUM_DOMAINS * 8;
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  // Queue storage. Each pointer has one extra wrap bit so that a full queue
  // can be told apart from an empty one.
  logic [2:0]   r_int_addr_mem [FIFO_DEPTH];
  logic [7:0]   r_int_data_mem [FIFO_DEPTH];
  logic [AW:0]  r_int_wr_ptr;
  logic [AW:0]  r_int_rd_ptr;
  logic [2:0]   r_rns_addr_mem [FIFO_DEPTH];
  logic [W-1:0] r_rns_data_mem [FIFO_DEPTH];
  logic [AW:0]  r_rns_wr_ptr;
  logic [AW:0]  r_rns_rd_ptr;

  // Arbitration history: 1 means the RNS queue won the last pop.
  logic         r_last_grant;

  // Registered write port.
  logic         r_wr_en;
  logic [3:0]   r_wr_addr;
  logic [W-1:0] r_wr_data;

  logic         w_int_empty;
  logic         w_int_full;
  logic         w_int_push;
  logic         w_int_pop;
  logic [AW:0]  w_int_count;
  logic         w_rns_empty;
  logic         w_rns_full;
  logic         w_rns_push;
  logic         w_rns_pop;
  logic [AW:0]  w_rns_count;
  logic [15:0]  w_int_hot [FIFO_DEPTH];
  logic [15:0]  w_rns_hot [FIFO_DEPTH];
  logic [15:0]  w_pending;

  assign w_int_empty = (r_int_wr_ptr == r_int_rd_ptr);
  assign w_int_full  = (r_int_wr_ptr[AW] != r_int_rd_ptr[AW]) &&
                       (r_int_wr_ptr[AW-1:0] == r_int_rd_ptr[AW-1:0]);
  assign w_int_count = r_int_wr_ptr - r_int_rd_ptr;

  assign w_rns_empty = (r_rns_wr_ptr == r_rns_rd_ptr);
  assign w_rns_full  = (r_rns_wr_ptr[AW] != r_rns_rd_ptr[AW]) &&
                       (r_rns_wr_ptr[AW-1:0] == r_rns_rd_ptr[AW-1:0]);
  assign w_rns_count = r_rns_wr_ptr - r_rns_rd_ptr;

  // Ready depends only on fullness and is forced low while reset is high.
  // A full queue refuses a push even if it pops in the same cycle.
  assign int_ready  = !w_int_full && !reset;
  assign rns_ready  = !w_rns_full && !reset;
  assign w_int_push = int_valid && int_ready;
  assign w_rns_push = rns_valid && rns_ready;

  // A lone non-empty queue always wins. On a tie, the source not served last wins.
  // The two pop terms are mutually exclusive by construction.
  assign w_int_pop = !w_int_empty && (w_rns_empty || r_last_grant);
  assign w_rns_pop = !w_rns_empty && (w_int_empty || !r_last_grant);

  // Queue writes. The storage has no reset because only the pointers decide
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (w_int_push) begin
      r_int_addr_mem[r_int_wr_ptr[AW-1:0]] <= int_addr;
      r_int_data_mem[r_int_wr_ptr[AW-1:0]] <= int_data;
    end
    if (w_rns_push) begin
      r_rns_addr_mem[r_rns_wr_ptr[AW-1:0]] <= rns_addr;
      r_rns_data_mem[r_rns_wr_ptr[AW-1:0]] <= rns_data;
    end
  end

  // Pointer update, arbitration and the registered write port.
  // Reset drops everything that is queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_int_wr_ptr <= '0;
      r_int_rd_ptr <= '0;
      r_rns_wr_ptr <= '0;
      r_rns_rd_ptr <= '0;
      r_last_grant <= 1'b1;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      if (w_int_push) r_int_wr_ptr <= r_int_wr_ptr + PTR_ONE;
      if (w_rns_push) r_rns_wr_ptr <= r_rns_wr_ptr + PTR_ONE;
      r_wr_en <= w_int_pop || w_rns_pop;
      if (w_int_pop) begin
        r_int_rd_ptr <= r_int_rd_ptr + PTR_ONE;
        r_last_grant <= 1'b0;
        r_wr_addr    <= {1'b0, r_int_addr_mem[r_int_rd_ptr[AW-1:0]]};
        r_wr_data    <= W'(r_int_data_mem[r_int_rd_ptr[AW-1:0]]);
      end else if (w_rns_pop) begin
        r_rns_rd_ptr <= r_rns_rd_ptr + PTR_ONE;
        r_last_grant <= 1'b1;
        r_wr_addr    <= {1'b1, r_rns_addr_mem[r_rns_rd_ptr[AW-1:0]]};
        r_wr_data    <= r_rns_data_mem[r_rns_rd_ptr[AW-1:0]];
      end
    end
  end

  // Every slot that lies within the live window contributes a one-hot bit
  // for its target register. Duplicate writes to the same register OR
  // together, so a bit stays set until the last of those writes has drained.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      logic [AW-1:0] w_int_rel;
      logic [AW-1:0] w_rns_rel;
      assign w_int_rel     = AW'(gi) - r_int_rd_ptr[AW-1:0];
      assign w_rns_rel     = AW'(gi) - r_rns_rd_ptr[AW-1:0];
      assign w_int_hot[gi] = ({1'b0, w_int_rel} < w_int_count) ?
                             (16'd1 << {1'b0, r_int_addr_mem[gi]}) : 16'd0;
      assign w_rns_hot[gi] = ({1'b0, w_rns_rel} < w_rns_count) ?
                             (16'd1 << {1'b1, r_rns_addr_mem[gi]}) : 16'd0;
    end
  endgenerate

  // Pending map: all live queue slots, plus the write that is currently on the port.
  always_comb begin
    w_pending = 16'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_pending = w_pending | w_int_hot[i] | w_rns_hot[i];
    end
    if (r_wr_en) w_pending = w_pending | (16'd1 << r_wr_addr);
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign pending = w_pending;
  assign idle    = w_int_empty && w_rns_empty && !r_wr_en;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter. It covers reset behaviour, a single write,
// pending tracking for duplicate addresses, queue fill and round-robin, and a
// reset that arrives while entries are still queued.
module tb_reg_wb_arbiter;
  localparam int ND = 2;
  localparam int W  = ND * 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         int_valid = 1'b0;
  logic         int_ready;
  logic [2:0]   int_addr = 3'd0;
  logic [7:0]   int_data = 8'd0;
  logic         rns_valid = 1'b0;
  logic         rns_ready;
  logic [2:0]   rns_addr = 3'd0;
  logic [W-1:0] rns_data = '0;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [15:0]  pending;
  logic         idle;

  int           n_checks = 0;
  int           n_errors = 0;
  int           i_idx;
  int           r_idx;
  int           n;
  logic         int_acc;
  logic         rns_acc;
  logic [3:0]   exp_addr;
  logic [15:0]  exp_data;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.NUM_DOMAINS(ND), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .int_valid(int_valid), .int_ready(int_ready), .int_addr(int_addr), .int_data(int_data),
    .rns_valid(rns_valid), .rns_ready(rns_ready), .rns_addr(rns_addr), .rns_data(rns_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending), .idle(idle)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // The design is held in reset and a request is presented; the request must be ignored.
    reset = 1'b1; int_valid = 1'b1; int_addr = 3'd7; int_data = 8'hFF;
    step(); step();
    check("rst int_ready", 32'(int_ready), 32'd0);
    check("rst rns_ready", 32'(rns_ready), 32'd0);
    check("rst wr_en",     32'(wr_en),     32'd0);
    check("rst wr_addr",   32'(wr_addr),   32'd0);
    check("rst wr_data",   32'(wr_data),   32'd0);
    check("rst pending",   32'(pending),   32'd0);
    check("rst idle",      32'(idle),      32'd1);
    reset = 1'b0; int_valid = 1'b0;
    #1;
    check("post-rst int_ready", 32'(int_ready), 32'd1);
    check("post-rst rns_ready", 32'(rns_ready), 32'd1);
    step();
    check("post-rst wr_en",   32'(wr_en),   32'd0);
    check("post-rst pending", 32'(pending), 32'd0);
    check("post-rst idle",    32'(idle),    32'd1);

    // A single integer write: addr 5, data 0x3C.
    int_valid = 1'b1; int_addr = 3'd5; int_data = 8'h3C;
    step();
    int_valid = 1'b0;
    check("single queued wr_en",   32'(wr_en),   32'd0);
    check("single queued pending", 32'(pending), 32'h0020);
    check("single queued idle",    32'(idle),    32'd0);
    step();
    check("single wr_en",   32'(wr_en),   32'd1);
    check("single wr_addr", 32'(wr_addr), 32'h5);
    check("single wr_data", 32'(wr_data), 32'h003C);
    check("single pending", 32'(pending), 32'h0020);
    step();
    check("single after wr_en",   32'(wr_en),   32'd0);
    check("single after wr_addr", 32'(wr_addr), 32'h5);
    check("single after pending", 32'(pending), 32'd0);
    check("single after idle",    32'(idle),    32'd1);

    // Two integer writes to register 3: pending[3] must survive the first write.
    int_valid = 1'b1; int_addr = 3'd3; int_data = 8'h11;
    step();
    check("dup q1 pending", 32'(pending), 32'h0008);
    check("dup q1 wr_en",   32'(wr_en),   32'd0);
    int_data = 8'h22;
    step();
    int_valid = 1'b0;
    check("dup w1 wr_en",   32'(wr_en),   32'd1);
    check("dup w1 wr_data", 32'(wr_data), 32'h0011);
    check("dup w1 pending", 32'(pending), 32'h0008);
    step();
    check("dup w2 wr_en",   32'(wr_en),   32'd1);
    check("dup w2 wr_data", 32'(wr_data), 32'h0022);
    check("dup w2 pending", 32'(pending), 32'h0008);
    step();
    check("dup end wr_en",   32'(wr_en),   32'd0);
    check("dup end pending", 32'(pending), 32'd0);

    // Both sources push every cycle, starting from a fresh reset so that the
    // integer queue wins the first tie. Pops alternate int/RNS. Both queues
    // fill up, and the data on the port proves there was no loss or duplication.
    reset = 1'b1;
    step();
    reset = 1'b0;
    i_idx = 0; r_idx = 0;
    for (int k = 1; k <= 20; k++) begin
      int_valid = 1'b1; int_addr = 3'(i_idx % 8); int_data = 8'(8'h10 + i_idx);
      rns_valid = 1'b1; rns_addr = 3'((r_idx + 3) % 8); rns_data = 16'(16'hA000 + r_idx);
      #1;
      int_acc = int_ready;
      rns_acc = rns_ready;
      step();
      if (int_acc) i_idx++;
      if (rns_acc) r_idx++;
      if (k >= 2) begin
        if (k % 2 == 0) begin
          n = (k - 2) / 2;
          exp_addr = {1'b0, 3'(n % 8)};
          exp_data = 16'(16'h0010 + n);
        end else begin
          n = (k - 3) / 2;
          exp_addr = {1'b1, 3'((n + 3) % 8)};
          exp_data = 16'(16'hA000 + n);
        end
        check($sformatf("rr wr_en e%0d", k),   32'(wr_en),   32'd1);
        check($sformatf("rr wr_addr e%0d", k), 32'(wr_addr), 32'(exp_addr));
        check($sformatf("rr wr_data e%0d", k), 32'(wr_data), 32'(exp_data));
      end
      if (k == 6) check("fill rns_ready e6", 32'(rns_ready), 32'd0);
      if (k == 7) begin
        check("fill rns_ready e7", 32'(rns_ready), 32'd1);
        check("fill int_ready e7", 32'(int_ready), 32'd0);
      end
      if (k == 8) begin
        check("fill int_ready e8", 32'(int_ready), 32'd1);
        check("fill rns_ready e8", 32'(rns_ready), 32'd0);
      end
    end

    // Reset arrives with both queues partly full: every queued entry is dropped.
    int_valid = 1'b0; rns_valid = 1'b0; reset = 1'b1;
    #1;
    check("midrst int_ready low", 32'(int_ready), 32'd0);
    check("midrst rns_ready low", 32'(rns_ready), 32'd0);
    step();
    check("midrst wr_en",   32'(wr_en),   32'd0);
    check("midrst pending", 32'(pending), 32'd0);
    check("midrst idle",    32'(idle),    32'd1);
    reset = 1'b0;
    #1;
    check("midrst int_ready", 32'(int_ready), 32'd1);
    check("midrst rns_ready", 32'(rns_ready), 32'd1);
    step();
    check("midrst after wr_en",   32'(wr_en),   32'd0);
    check("midrst after idle",    32'(idle),    32'd1);
    check("midrst after pending", 32'(pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 2; RNS data width W = NUM_DOMAINS*8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; per-source queue depth, power of two, at least 2.
REQ-003 SHALL have one clock and a reset that is synchronous and active-high.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 int_valid  input  1  integer-domain write request present.
REQ-007 int_ready  output  1  integer queue can accept a request.
REQ-008 int_addr  input  3  integer register index.
REQ-009 int_data  input  8  integer write data.
REQ-010 rns_valid  input  1  RNS-domain write request present.
REQ-011 rns_ready  output  1  RNS queue can accept a request.
REQ-012 rns_addr  input  3  RNS register index.
REQ-013 rns_data  input  W  RNS write data.
REQ-014 wr_en  output  1  register-file write strobe, registered.
REQ-015 wr_addr  output  4  register-file write address, registered; bit 3 set means RNS file.
REQ-016 wr_data  output  W  register-file write data, registered.
REQ-017 pending  output  16  bit {file,index} set while a write to that register is queued or on the outputs.
REQ-018 idle  output  1  both queues empty and wr_en low.

Function
REQ-019 SHALL accept an integer request at a rising edge when int_valid and int_ready are both high; RNS requests follow the same rule.
REQ-020 SHALL drive int_ready = !int_full and rns_ready = !rns_full, independent of valid.
REQ-021 SHALL hold both ready outputs low while reset is high.
REQ-022 SHALL NOT accept a push into a full queue, even when that queue pops in the same cycle.
REQ-023 SHALL support a simultaneous push and pop on a non-full, non-empty queue, with occupancy unchanged.
REQ-024 SHALL provide no bypass: an entry pushed at edge k is first poppable at edge k+1.
REQ-025 SHALL pop at most one entry per edge, from one queue only.
REQ-026 When only one queue is non-empty, SHALL pop that queue.
REQ-027 When both queues are non-empty, SHALL grant the source not granted last (round-robin), then update last_grant.
REQ-028 SHALL initialise last_grant to RNS on reset, so the integer queue wins the first tie.
REQ-029 On a pop at edge k, SHALL register wr_en=1, wr_addr={file,index} and wr_data in the same edge, visible for the cycle after k.
REQ-030 SHALL present integer data as wr_data = {(W-8) zeros, int_data} with wr_addr[3]=0.
REQ-031 SHALL present RNS data as wr_data = rns_data with wr_addr[3]=1.
REQ-032 SHALL set wr_en=0 when no pop occurs at an edge, with wr_addr/wr_data holding their last values.
REQ-033 SHALL give an accept-to-register-file-write-edge latency of 2 cycles minimum with an empty, uncontended path.
REQ-034 SHALL write each queue's entries in acceptance order; there is no ordering guarantee across queues.
REQ-035 SHALL compute pending combinationally as the OR over valid queue entries plus the output register when wr_en=1.
REQ-036 Pending SHALL count duplicate addresses correctly: the bit stays set until the last queued write to that register has left the outputs.
REQ-037 SHALL wrap queue pointers modulo FIFO_DEPTH and distinguish full from empty with one extra pointer bit.

Reset
REQ-038 On reset SHALL clear all queue pointers, wr_en, wr_addr, wr_data and pending, and set idle=1.
REQ-039 A reset asserted mid-operation SHALL discard all queued entries, with no write strobe in the cycle after the reset edge.
REQ-040 SHALL ignore valid inputs during the reset cycle.

Verification
REQ-041 Single integer request addr=5, data=0x3C -> wr_en=1, wr_addr=0x5, wr_data=0x003C in the cycle after the pop; pending[5] clears after that cycle.
REQ-042 Integer and RNS requests presented together every cycle (int addr=1, rns addr=2, data=0xABCD) -> writes alternate int, RNS, int, ... starting with int; wr_addr alternates 0x1, 0xA.
REQ-043 Five RNS pushes with no pops possible (depth 4, integer queue kept busy) -> rns_ready=0 after the 4th accept; the 5th is held until a slot frees, and no data is lost or duplicated.
REQ-044 Two queued integer writes to addr 3 -> pending[3] stays 1 until the second write's wr_en cycle ends, then 0.
REQ-045 Reset asserted with 3 entries queued -> next cycle wr_en=0, pending=0, idle=1, and both ready outputs are 1 after reset deasserts.
REQ-046 Random traffic, 10k cycles -> the scoreboard model matches every wr_en/wr_addr/wr_data, and per-source order is preserved.
